// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 3;
  localparam int unsigned DEF_SRAM_AW     = 18;

  // Word offset of a byte address from the SRAM base; low two bits drop out.
  function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side bus between EX/MEM, the SRAM controller and MEM/WB.
interface mem_sram_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] alu_res;
  logic [31:0] rm_val;
  logic [31:0] data_mem;
  logic        ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, alu_res, rm_val,
    input  data_mem, ready
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, alu_res, rm_val,
    output data_mem, ready
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Multi-cycle MEM stage: each 32-bit access becomes two 16-bit SRAM phases
// while ready is held low to freeze the pipeline.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  mem_sram_ctrl_if.slave     pipe,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  state_t             state;
  op_t                op;
  logic [CW-1:0]      cnt;
  logic [SRAM_AW-2:0] idx;
  logic [15:0]        wdata_hi;
  logic [31:0]        rdata;

  logic               req;
  logic [SRAM_AW-2:0] req_idx;

  always_comb begin
    req     = pipe.MEM_R_EN | pipe.MEM_W_EN;
    req_idx = (SRAM_AW-1)'(word_offset(pipe.alu_res, 32'(BASE_ADDR)));
  end

  always_comb begin
    pipe.ready    = ((state == IDLE) && !req) || (state == DONE);
    pipe.data_mem = '0;
    if (state == DONE && op == OP_RD && pipe.MEM_R_EN)
      pipe.data_mem = rdata;
  end

  // Bus pins are registered: each transition loads the values for the phase
  // being entered, so an async reset returns the bus to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op          <= OP_RD;
      cnt         <= '0;
      idx         <= '0;
      wdata_hi    <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op          <= pipe.MEM_W_EN ? OP_WR : OP_RD;
            idx         <= req_idx;
            wdata_hi    <= pipe.rm_val[31:16];
            cnt         <= '0;
            state       <= LOW;
            sram_addr   <= {req_idx, 1'b0};
            sram_we_n   <= !pipe.MEM_W_EN;
            sram_dq_oe  <= pipe.MEM_W_EN;
            sram_dq_out <= pipe.MEM_W_EN ? pipe.rm_val[15:0] : '0;
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (op == OP_RD)
              rdata[15:0] <= sram_dq_in;
            state       <= HIGH;
            sram_addr   <= {idx, 1'b1};
            sram_dq_out <= (op == OP_WR) ? wdata_hi : '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (op == OP_RD)
              rdata[31:16] <= sram_dq_in;
            state       <= DONE;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a per-cycle access-timeline model.
module tb_mem_sram_ctrl;
  import mem_pkg::*;

  localparam int W  = 3;
  localparam int AW = 18;
  localparam int IDX_MASK = (1 << (AW - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_sram_ctrl_if pipe();

  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;

  mem_sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe        (pipe),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  // Behavioural SRAM: combinational read, write on clock edges while we_n low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq_in = sram_dq_oe ? 16'h0000 : sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: acc_t counts cycles since the request was accepted (0 = idle).
  int          acc_t = 0;
  bit          acc_wr;
  int          acc_idx;
  logic [31:0] acc_wdata;
  logic [31:0] acc_rdata;
  logic [31:0] exp_word [int];
  int          we_low = 0;

  always @(negedge clk) begin
    bit          req, ph;
    logic        e_ready, e_we_n, e_oe;
    logic [31:0] e_data;
    int          e_addr;
    req = pipe.MEM_R_EN | pipe.MEM_W_EN;
    if (rst) begin
      if (acc_t > 0 && acc_wr) exp_word.delete(acc_idx);
      acc_t = 0;
    end
    e_ready = 1'b0; e_we_n = 1'b1; e_oe = 1'b0; e_data = '0; e_addr = 0;
    if (acc_t == 0) begin
      e_ready = !req;
    end else if (acc_t <= 2 * W) begin
      ph     = (acc_t > W);
      e_we_n = !acc_wr;
      e_oe   = acc_wr;
      e_addr = 2 * acc_idx + int'(ph);
      if (acc_wr)
        chk("dq_out", 32'(sram_dq_out), ph ? 32'(acc_wdata[31:16]) : 32'(acc_wdata[15:0]));
    end else begin
      e_ready = 1'b1;
      if (!acc_wr && pipe.MEM_R_EN) e_data = acc_rdata;
    end
    chk("ready",    32'(pipe.ready), 32'(e_ready));
    chk("we_n",     32'(sram_we_n),  32'(e_we_n));
    chk("dq_oe",    32'(sram_dq_oe), 32'(e_oe));
    chk("addr",     32'(sram_addr),  32'(e_addr));
    chk("data_mem", pipe.data_mem,   e_data);
    if (acc_t == 0 || acc_t > 2 * W) chk("dq_idle", 32'(sram_dq_out), 32'h0);
    if (!sram_we_n) we_low++;
    if (!rst) begin
      if (acc_t == 0) begin
        if (req) begin
          acc_t     = 1;
          acc_wr    = pipe.MEM_W_EN;
          acc_idx   = int'((pipe.alu_res - 32'd1024) >> 2) & IDX_MASK;
          acc_wdata = pipe.rm_val;
          if (acc_wr) exp_word[acc_idx] = pipe.rm_val;
          else acc_rdata = exp_word.exists(acc_idx) ? exp_word[acc_idx] : 32'h0;
        end
      end else if (acc_t == 2 * W + 1) begin
        acc_t = 0;
      end else begin
        acc_t++;
      end
    end
  end

  // Runs one access, returning ready-low cycles, data_mem in the ready-high
  // cycle that ends it, and how many cycles sram_we_n was low.
  task automatic run_access(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input bit hold,
                            output int stalls, output logic [31:0] done_data,
                            output int we_cnt, output bit immediate);
    bit ok = 0;
    @(posedge clk); #1;
    pipe.MEM_R_EN = r; pipe.MEM_W_EN = w; pipe.alu_res = a; pipe.rm_val = d;
    we_low = 0;
    stalls = 0; done_data = 'x; immediate = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) immediate = !pipe.ready;
      if (!pipe.ready) stalls++;
      else if (stalls > 0) begin
        done_data = pipe.data_mem;
        ok = 1;
        break;
      end
    end
    we_cnt = we_low;
    if (!ok) chk("access_timeout", 32'(ok), 32'd1);
    if (!hold) begin
      @(posedge clk); #1;
      pipe.MEM_R_EN = 0; pipe.MEM_W_EN = 0;
    end
  endtask

  initial begin
    int s1, s2, wc;
    bit imm;
    logic [31:0] dd;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
    sram_mem[7] = 16'h1111;
    pipe.MEM_R_EN = 0; pipe.MEM_W_EN = 0; pipe.alu_res = 0; pipe.rm_val = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    chk("rst_ready", 32'(pipe.ready), 32'd1);
    chk("rst_we_n",  32'(sram_we_n),  32'd1);
    chk("rst_oe",    32'(sram_dq_oe), 32'd0);
    chk("rst_data",  pipe.data_mem,   32'h0);
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", 32'(pipe.ready), 32'd1);
    end

    run_access(0, 1, 32'd1028, 32'hDEADBEEF, 0, s1, dd, wc, imm);
    chk("wr_stalls", 32'(s1), 32'd7);
    chk("wr_we_low", 32'(wc), 32'd6);
    chk("wr_data_mem", dd, 32'h0);
    chk("mem2", 32'(sram_mem[2]), 32'h0000BEEF);
    chk("mem3", 32'(sram_mem[3]), 32'h0000DEAD);

    run_access(1, 0, 32'd1028, 32'h0, 0, s1, dd, wc, imm);
    chk("rd_stalls", 32'(s1), 32'd7);
    chk("rd_done_data", dd, 32'hDEADBEEF);
    chk("rd_we_low", 32'(wc), 32'd0);
    @(negedge clk);
    chk("rd_after_data", pipe.data_mem, 32'h0);

    run_access(0, 1, 32'd1032, 32'h12345678, 1, s1, dd, wc, imm);
    run_access(1, 0, 32'd1032, 32'h0, 0, s2, dd, wc, imm);
    chk("b2b_stalls", 32'(s1 + s2), 32'd14);
    chk("b2b_immediate", 32'(imm), 32'd1);
    chk("b2b_data", dd, 32'h12345678);

    run_access(1, 1, 32'd1024, 32'hA5A5A5A5, 0, s1, dd, wc, imm);
    chk("both_data", dd, 32'h0);
    chk("both_mem0", 32'(sram_mem[0]), 32'h0000A5A5);
    chk("both_mem1", 32'(sram_mem[1]), 32'h0000A5A5);

    @(posedge clk); #1;
    pipe.MEM_W_EN = 1; pipe.alu_res = 32'd1036; pipe.rm_val = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1 rst = 1; pipe.MEM_W_EN = 0;
    #1;
    chk("abort_we_n",  32'(sram_we_n),  32'd1);
    chk("abort_ready", 32'(pipe.ready), 32'd1);
    chk("abort_oe",    32'(sram_dq_oe), 32'd0);
    @(negedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 chk("abort_mem7", 32'(sram_mem[7]), 32'h00001111);

    run_access(1, 0, 32'd1024, 32'h0, 0, s1, dd, wc, imm);
    chk("post_rst_rd", dd, 32'hA5A5A5A5);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
